// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt coalescer: FSM encoding and default sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irq_pkg;

   localparam int NUM_CH_DEF  = 2;
   localparam int TIMER_W_DEF = 16;
   localparam int CNT_W_DEF   = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_REQ  = 2'd2
   } state_e;

endpackage

// File: rtl/irq_popcount.sv
// Counts the set bits of a completion vector to form the event-counter increment.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result follows the input.
module irq_popcount #(
   parameter int NUM_CH = 2,
   parameter int PC_W   = $clog2(NUM_CH + 1)
) (
   input  logic [NUM_CH-1:0] vec_i,
   output logic [PC_W-1:0]   cnt_o
);

   // Ripple-add every bit; NUM_CH is at most 16 so the chain stays short.
   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_o = cnt_o + PC_W'(vec_i[i]);
      end
   end

endmodule

// File: rtl/irq_coalescer.sv
// Coalesces per-channel write completions into one held interrupt request with holdoff/threshold.
// Latency: request registered two edges after a falling wt_busy is first sampled when holdoff=0.
// Backpressure: request held until data_rdy_ack; firing deferred while any channel is still busy.
module irq_coalescer
   import irq_pkg::*;
#(
   parameter int NUM_CH  = NUM_CH_DEF,   // legal range 1..16
   parameter int TIMER_W = TIMER_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               irq_en,
   input  logic [TIMER_W-1:0] holdoff,
   input  logic [CNT_W-1:0]   pkt_thresh,
   input  logic [NUM_CH-1:0]  wt_busy,
   output logic               data_rdy,
   output logic [NUM_CH-1:0]  irq_src,
   input  logic               data_rdy_ack
);

   localparam int PW = $clog2(NUM_CH + 1);
   localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e             state_q, state_d;
   logic [NUM_CH-1:0]  busy_q, busy_qq;
   logic [NUM_CH-1:0]  pend_q, pend_d;
   logic [CNT_W-1:0]   evt_q, evt_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               rdy_q, rdy_d;
   logic [NUM_CH-1:0]  src_q, src_d;

   logic [NUM_CH-1:0]  comp;
   logic [NUM_CH-1:0]  pend_all;
   logic [PW-1:0]      pop;
   logic [SW-1:0]      evt_sum;
   logic [CNT_W-1:0]   evt_acc;
   logic               thresh_hit;
   logic               fire;

   // A completion is a channel sampled busy on one edge and idle on the next.
   assign comp     = busy_qq & ~busy_q;
   assign pend_all = pend_q | comp;

   irq_popcount #(
      .NUM_CH (NUM_CH),
      .PC_W   (PW)
   ) u_popcount (
      .vec_i (comp),
      .cnt_o (pop)
   );

   // Saturating accumulate of this cycle's completions.
   assign evt_sum = SW'(evt_q) + SW'(pop);
   assign evt_acc = (evt_sum > SW'(CNT_MAX)) ? CNT_MAX : evt_sum[CNT_W-1:0];

   assign thresh_hit = (pkt_thresh != '0) && (evt_q >= pkt_thresh);
   assign fire       = (state_q == S_WAIT) && ((timer_q == '0) || thresh_hit) &&
                       (busy_q == '0) && irq_en;

   // Next-state and output decode; everything defaults to hold/accumulate.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      pend_d  = pend_all;
      evt_d   = evt_acc;
      rdy_d   = rdy_q;
      src_d   = src_q;
      case (state_q)
         S_IDLE: begin
            if (comp != '0) begin
               state_d = S_WAIT;
               timer_d = holdoff;
            end
         end
         S_WAIT: begin
            timer_d = (timer_q == '0) ? '0 : timer_q - TIMER_W'(1);
            if (fire) begin
               // The mask moves into irq_src here, so anything completing while the
               // request is outstanding (even on a reported channel) seeds the next one.
               state_d = S_REQ;
               rdy_d   = 1'b1;
               src_d   = pend_all;
               pend_d  = '0;
               evt_d   = '0;
               timer_d = '0;
            end
         end
         S_REQ: begin
            if (data_rdy_ack) begin
               rdy_d = 1'b0;
               src_d = '0;
               if (pend_all != '0) begin
                  state_d = S_WAIT;
                  timer_d = holdoff;
               end else begin
                  state_d = S_IDLE;
                  timer_d = '0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any outstanding request immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         busy_q  <= '0;
         busy_qq <= '0;
         pend_q  <= '0;
         evt_q   <= '0;
         timer_q <= '0;
         rdy_q   <= 1'b0;
         src_q   <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= wt_busy;
         busy_qq <= busy_q;
         pend_q  <= pend_d;
         evt_q   <= evt_d;
         timer_q <= timer_d;
         rdy_q   <= rdy_d;
         src_q   <= src_d;
      end
   end

   assign data_rdy = rdy_q;
   assign irq_src  = src_q;

endmodule

// File: tb/tb_irq_coalescer.sv
// Directed bench for irq_coalescer: cycle table on a 2-channel instance plus hand sequences.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: ack driven explicitly per vector.
module tb_irq_coalescer;

   logic        clk;
   logic        rst;
   logic        irq_en;
   logic [15:0] holdoff;
   logic [7:0]  pkt_thresh;
   logic        ack;
   logic [1:0]  busy2;
   logic [3:0]  busy4;
   logic        rdy2, rdy4;
   logic [1:0]  src2;
   logic [3:0]  src4;

   int checks   = 0;
   int failures = 0;

   irq_coalescer #(.NUM_CH(2), .TIMER_W(16), .CNT_W(8)) dut2 (
      .clk          (clk),
      .rst          (rst),
      .irq_en       (irq_en),
      .holdoff      (holdoff),
      .pkt_thresh   (pkt_thresh),
      .wt_busy      (busy2),
      .data_rdy     (rdy2),
      .irq_src      (src2),
      .data_rdy_ack (ack)
   );

   irq_coalescer #(.NUM_CH(4), .TIMER_W(16), .CNT_W(8)) dut4 (
      .clk          (clk),
      .rst          (rst),
      .irq_en       (irq_en),
      .holdoff      (holdoff),
      .pkt_thresh   (pkt_thresh),
      .wt_busy      (busy4),
      .data_rdy     (rdy4),
      .irq_src      (src4),
      .data_rdy_ack (ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [15:0] hold;
      logic [7:0]  thr;
      logic [1:0]  busy;
      logic        ack;
      int          rep;
      logic        exp_rdy;
      logic [1:0]  exp_src;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic en, input logic [15:0] hold, input logic [7:0] thr,
                               input logic [1:0] busy, input logic a, input int rep,
                               input logic exp_rdy, input logic [1:0] exp_src);
      vec_t v;
      v.en = en; v.hold = hold; v.thr = thr; v.busy = busy; v.ack = a;
      v.rep = rep; v.exp_rdy = exp_rdy; v.exp_src = exp_src;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      int rises;

      // Columns: en, holdoff, thresh, busy, ack, repeat, exp data_rdy, exp irq_src
      tbl.push_back(mk(1,   0, 0, 2'b00, 0,  2, 0, 2'b00));
      tbl.push_back(mk(1,   0, 0, 2'b01, 0,  3, 0, 2'b00)); // ch0 busy 3 cycles
      tbl.push_back(mk(1,   0, 0, 2'b00, 0,  2, 0, 2'b00)); // fall sampled, then WAIT
      tbl.push_back(mk(1,   0, 0, 2'b00, 0,  2, 1, 2'b01)); // fires 2 edges after fall, held
      tbl.push_back(mk(1,   0, 0, 2'b00, 1,  1, 0, 2'b00)); // ack clears
      tbl.push_back(mk(1,   0, 0, 2'b00, 1,  2, 0, 2'b00)); // ack ignored in idle
      tbl.push_back(mk(1,  10, 0, 2'b10, 0,  2, 0, 2'b00)); // ch1 busy
      tbl.push_back(mk(1,  10, 0, 2'b00, 0,  1, 0, 2'b00)); // t: fall sampled
      tbl.push_back(mk(1,  10, 0, 2'b00, 0,  1, 0, 2'b00)); // t+1: timer loaded with 10
      tbl.push_back(mk(1,   3, 0, 2'b00, 0, 10, 0, 2'b00)); // holdoff change must not matter
      tbl.push_back(mk(1,   3, 0, 2'b00, 0,  1, 1, 2'b10)); // t+12
      tbl.push_back(mk(0,   0, 0, 2'b00, 0,  2, 1, 2'b10)); // irq_en low keeps raised request
      tbl.push_back(mk(1,   0, 0, 2'b01, 0,  2, 1, 2'b10)); // ch0 busy during request
      tbl.push_back(mk(1,   0, 0, 2'b00, 0,  1, 1, 2'b10)); // ch0 fall sampled
      tbl.push_back(mk(1,   0, 0, 2'b00, 1,  1, 0, 2'b00)); // ack, ch0 pending
      tbl.push_back(mk(1,   0, 0, 2'b00, 0,  1, 1, 2'b01)); // second request
      tbl.push_back(mk(1,   0, 0, 2'b00, 1,  1, 0, 2'b00));
      tbl.push_back(mk(1,   0, 0, 2'b00, 0,  2, 0, 2'b00));
      tbl.push_back(mk(0,   0, 0, 2'b01, 0,  2, 0, 2'b00)); // disabled, events arrive
      tbl.push_back(mk(0,   0, 0, 2'b00, 0,  4, 0, 2'b00)); // blocked by irq_en
      tbl.push_back(mk(1,   0, 0, 2'b00, 0,  1, 1, 2'b01)); // fires the edge after enable
      tbl.push_back(mk(1,   0, 0, 2'b00, 1,  1, 0, 2'b00));
      tbl.push_back(mk(1, 1000, 2, 2'b11, 0,  2, 0, 2'b00)); // both channels busy
      tbl.push_back(mk(1, 1000, 2, 2'b00, 0,  2, 0, 2'b00)); // simultaneous fall, count += 2
      tbl.push_back(mk(1, 1000, 2, 2'b00, 0,  1, 1, 2'b11)); // threshold 2 met at once
      tbl.push_back(mk(1,   0, 0, 2'b00, 1,  1, 0, 2'b00));

      rst = 1'b0; irq_en = 1'b1; holdoff = '0; pkt_thresh = '0; ack = 1'b0;
      busy2 = '0; busy4 = '0;
      step();
      step();
      check("reset_rdy2", 32'(rdy2), 32'd0);
      check("reset_src2", 32'(src2), 32'd0);
      check("reset_rdy4", 32'(rdy4), 32'd0);
      check("reset_src4", 32'(src4), 32'd0);
      rst = 1'b1;

      // Table-driven cycle vectors on the 2-channel instance
      for (int r = 0; r < tbl.size(); r++) begin
         for (int k = 0; k < tbl[r].rep; k++) begin
            irq_en = tbl[r].en; holdoff = tbl[r].hold; pkt_thresh = tbl[r].thr;
            busy2 = tbl[r].busy; ack = tbl[r].ack;
            step();
            check($sformatf("row%0d_%0d_rdy", r, k), 32'(rdy2), 32'(tbl[r].exp_rdy));
            check($sformatf("row%0d_%0d_src", r, k), 32'(src2), 32'(tbl[r].exp_src));
         end
      end
      ack = 1'b0; busy2 = '0; irq_en = 1'b1;

      // Threshold beats a long holdoff on the 4-channel instance
      holdoff = 16'd1000; pkt_thresh = 8'd4;
      busy4 = 4'b1111; step(); step();
      busy4 = 4'b1110; step();
      busy4 = 4'b1100; step();
      busy4 = 4'b1000; step();
      busy4 = 4'b0000; step();
      step();
      check("thr4_before", 32'(rdy4), 32'd0);
      step();
      check("thr4_rdy", 32'(rdy4), 32'd1);
      check("thr4_src", 32'(src4), 32'hf);
      ack = 1'b1; step(); ack = 1'b0;
      check("thr4_ack", 32'(rdy4), 32'd0);
      holdoff = '0; pkt_thresh = '0;

      // ch0 completes while ch1 stays busy for 50 cycles: one merged request
      busy2 = 2'b11; step(); step();
      busy2 = 2'b10; step();
      rises = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (rdy2) rises++;
      end
      check("merge_hold_while_busy", 32'(rises), 32'd0);
      busy2 = 2'b00; step();
      check("merge_fall_edge", 32'(rdy2), 32'd0);
      step();
      check("merge_rdy", 32'(rdy2), 32'd1);
      check("merge_src", 32'(src2), 32'h3);
      ack = 1'b1; step(); ack = 1'b0;
      check("merge_ack", 32'(rdy2), 32'd0);
      rises = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (rdy2) rises++;
      end
      check("merge_single", 32'(rises), 32'd0);

      // Asynchronous reset in S_REQ, channel busy across reset release
      busy2 = 2'b01; step(); step();
      busy2 = 2'b00; step(); step(); step();
      check("rst_pre_rdy", 32'(rdy2), 32'd1);
      #2;
      rst = 1'b0; busy2 = 2'b01;
      #1;
      check("rst_async_rdy", 32'(rdy2), 32'd0);
      check("rst_async_src", 32'(src2), 32'd0);
      step();
      check("rst_hold_rdy", 32'(rdy2), 32'd0);
      rst = 1'b1;
      step();
      busy2 = 2'b00; step();
      check("rst_fall", 32'(rdy2), 32'd0);
      step();
      check("rst_wait", 32'(rdy2), 32'd0);
      step();
      check("rst_busy_at_release_rdy", 32'(rdy2), 32'd1);
      check("rst_busy_at_release_src", 32'(src2), 32'h1);
      ack = 1'b1; step(); ack = 1'b0;
      check("rst_final_ack", 32'(rdy2), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/irq_coalescer.md
IRQ_COALESCER -- requirements
Module: irq_coalescer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter NUM_CH, default 2, is the number of write-completion channels; the legal range SHALL be 1..16.
REQ-003 Parameter TIMER_W, default 16, is the holdoff timer width in bits.
REQ-004 Parameter CNT_W, default 8, is the event counter width in bits.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- irq_en  in  1  interrupt enable
- holdoff  in  TIMER_W  holdoff in cycles; 0 = no holdoff
- pkt_thresh  in  CNT_W  early-fire event count; 0 = disabled
- wt_busy  in  NUM_CH  per-channel buffer-write-in-progress flag
- data_rdy  out  1  interrupt request
- irq_src  out  NUM_CH  channels covered by the current request
- data_rdy_ack  in  1  host acknowledge

Function
REQ-006 A completion event on channel i SHALL be wt_busy[i] sampled 1 on one edge and 0 on the next; the block SHALL register wt_busy for this edge detection.
REQ-007 pend_mask SHALL OR in every completion vector each cycle.
REQ-008 evt_cnt SHALL add the popcount of the completion vector each cycle and SHALL saturate at 2^CNT_W-1.
REQ-009 The FSM SHALL have exactly three states: S_IDLE, S_WAIT and S_REQ.
REQ-010 S_IDLE: on any completion, the FSM SHALL go to S_WAIT and load timer with holdoff.
REQ-011 S_WAIT: the timer SHALL decrement each cycle and hold at 0.
REQ-012 S_WAIT: fire SHALL be true when (timer==0, or pkt_thresh!=0 and evt_cnt>=pkt_thresh) and wt_busy==0 and irq_en==1.
REQ-013 On fire: go to S_REQ, set data_rdy=1, set irq_src=pend_mask (including completions in the same cycle).
REQ-014 While any wt_busy bit is 1, the block SHALL defer firing, collapsing all completions into one request.
REQ-015 S_REQ: data_rdy and irq_src SHALL hold stable until data_rdy_ack==1 is sampled.
REQ-016 On ack in S_REQ, the block SHALL:
- set data_rdy=0 and irq_src=0;
- clear the irq_src bits from pend_mask;
- set evt_cnt to the events received during S_REQ, including the ack cycle.
REQ-017 After ack: if any events are pending, go to S_WAIT and reload timer=holdoff; otherwise go to S_IDLE.
REQ-018 data_rdy_ack SHALL be ignored outside S_REQ.
REQ-019 With holdoff=0 and an idle block, data_rdy SHALL rise on the 2nd clock edge after the edge that first samples wt_busy[i]=0.
REQ-020 irq_en=0 SHALL block firing while events keep accumulating; an already-raised request SHALL be unaffected.
REQ-021 When irq_en rises with events pending and the timer at 0, the block SHALL fire on the next edge if wt_busy==0.
REQ-022 holdoff and pkt_thresh SHALL be sampled only at timer load and in the compare; mid-operation changes SHALL not corrupt state.
REQ-023 Simultaneous completions on several channels SHALL add their full popcount to evt_cnt in one cycle.

Reset
REQ-024 While rst==0, the block SHALL hold: state=S_IDLE, data_rdy=0, irq_src=0, pend_mask=0, evt_cnt=0, timer=0, wt_busy history=0.
REQ-025 A channel busy at reset release SHALL count as a completion when it falls.
REQ-026 Reset mid-request SHALL drop the request with no ack required.

Structure
REQ-027 Package irq_pkg SHALL hold the state encoding and the default values of NUM_CH, TIMER_W and CNT_W.
REQ-028 One sub-module, irq_popcount (NUM_CH in, clog2(NUM_CH+1) out, combinational), SHALL compute the event increment.
REQ-029 Outputs SHALL be registered, with no combinational path from input to output.

Verification
REQ-030 NUM_CH=2, holdoff=0, thresh=0: pulse wt_busy[0] high for 3 cycles -> data_rdy=1 two edges after the fall, irq_src=2'b01; ack -> data_rdy=0 next edge, S_IDLE.
REQ-031 holdoff=10: completion on ch1 at t -> data_rdy rises at t+12, irq_src=2'b10.
REQ-032 holdoff=1000, thresh=4, NUM_CH=4: four completions over 4 cycles -> fires on the threshold, well before the timer expires, irq_src=4'b1111.
REQ-033 ch0 completes while ch1 is still busy for 50 cycles, holdoff=0 -> a single request after ch1 falls, irq_src=2'b11.
REQ-034 Completion on ch0 during S_REQ, then ack -> a second request follows with irq_src=2'b01.
REQ-035 irq_en=0, then events, then irq_en=1 -> fires next edge; rst=0 asserted in S_REQ -> data_rdy drops asynchronously to 0.
